// File: rtl/ok_fifo64x8_reader_pkg.sv
// Shared sizing constants and output-stage state encoding for the 64x8 reader FIFO.
// No logic; imported by the RAM and the FIFO top.
// Keep these in sync with the port widths the consumers expect.
package ok_fifo64x8_reader_pkg;

    localparam int DEPTH = 64;
    localparam int AW    = 6;
    localparam int DW    = 8;
    localparam int CW    = 7;

    typedef enum logic {
        OST_EMPTY = 1'b0,
        OST_HOLD  = 1'b1
    } ostate_e;

endpackage

// File: rtl/ok_fifo64x8_reader_dpram.sv
// 64x8 dual-port RAM: synchronous write port, asynchronous read port.
// Read data is valid in the same cycle as the read address; writes land on the rising edge.
// No flow control; the caller owns pointer management.
module ok_dpram64x8
    import ok_fifo64x8_reader_pkg::*;
(
    input  logic          clk_i,
    input  logic          wr_en_i,
    input  logic [AW-1:0] wr_addr_i,
    input  logic [DW-1:0] wr_din_i,
    input  logic [AW-1:0] rd_addr_i,
    output logic [DW-1:0] rd_dout_o
);

    // Contents are deliberately left unreset; occupancy tracking makes stale words unreachable.
    logic [DW-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_din_i;
        end
    end

    assign rd_dout_o = mem_q[rd_addr_i];

endmodule

// File: rtl/ok_fifo64x8_reader.sv
// 64-word FIFO with a registered output stage (valid/ready); occupancy counts RAM plus output stage.
// A write reaches dout_valid two edges after it is sampled; no bypass path.
// dout is held stable while dout_ready is low; writes while full are dropped and flagged sticky.
module ok_fifo64x8_reader
    import ok_fifo64x8_reader_pkg::*;
#(
    parameter int AFULL_THRESH  = 56,
    parameter int AEMPTY_THRESH = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          flush,
    input  logic          wr_en,
    input  logic [DW-1:0] din,
    output logic          full,
    output logic [DW-1:0] dout,
    output logic          dout_valid,
    input  logic          dout_ready,
    output logic [CW-1:0] count,
    output logic          almost_full,
    output logic          almost_empty,
    output logic          overflow
);

    localparam logic [CW-1:0] AF_T  = CW'(AFULL_THRESH);
    localparam logic [CW-1:0] AE_T  = CW'(AEMPTY_THRESH);
    localparam logic [CW-1:0] CNT_F = CW'(DEPTH);

    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] ram_cnt_q, ram_cnt_d;
    ostate_e       state_q, state_d;
    logic [DW-1:0] dout_q, dout_d;
    logic          ovf_q, ovf_d;

    logic          wr_acc;
    logic          load;
    logic          ram_we;
    logic [DW-1:0] rd_dat;

    ok_dpram64x8 u_ram (
        .clk_i     (clk),
        .wr_en_i   (ram_we),
        .wr_addr_i (wptr_q),
        .wr_din_i  (din),
        .rd_addr_i (rptr_q),
        .rd_dout_o (rd_dat)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr_q    <= '0;
            rptr_q    <= '0;
            ram_cnt_q <= '0;
            state_q   <= OST_EMPTY;
            dout_q    <= '0;
            ovf_q     <= 1'b0;
        end else begin
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            ram_cnt_q <= ram_cnt_d;
            state_q   <= state_d;
            dout_q    <= dout_d;
            ovf_q     <= ovf_d;
        end
    end

    always_comb begin
        wptr_d    = wptr_q;
        rptr_d    = rptr_q;
        ram_cnt_d = ram_cnt_q;
        state_d   = state_q;
        dout_d    = dout_q;
        ovf_d     = ovf_q;

        wr_acc = wr_en && !full;
        load   = (ram_cnt_q != '0) && ((state_q == OST_EMPTY) || dout_ready);
        ram_we = wr_acc && !flush;

        if (flush) begin
            // dout keeps its last value; dout_valid low already makes it meaningless.
            wptr_d    = '0;
            rptr_d    = '0;
            ram_cnt_d = '0;
            state_d   = OST_EMPTY;
            ovf_d     = 1'b0;
        end else begin
            if (wr_en && full) begin
                ovf_d = 1'b1;
            end
            if (wr_acc) begin
                wptr_d = wptr_q + AW'(1);
            end
            if (load) begin
                rptr_d  = rptr_q + AW'(1);
                dout_d  = rd_dat;
                state_d = OST_HOLD;
            end else if ((state_q == OST_HOLD) && dout_ready) begin
                state_d = OST_EMPTY;
            end
            case ({wr_acc, load})
                2'b10:   ram_cnt_d = ram_cnt_q + CW'(1);
                2'b01:   ram_cnt_d = ram_cnt_q - CW'(1);
                default: ram_cnt_d = ram_cnt_q;
            endcase
        end
    end

    assign full         = (ram_cnt_q == CNT_F);
    assign dout         = dout_q;
    assign dout_valid   = (state_q == OST_HOLD);
    assign count        = ram_cnt_q + {{(CW-1){1'b0}}, dout_valid};
    assign almost_full  = (count >= AF_T);
    assign almost_empty = (count <= AE_T);
    assign overflow     = ovf_q;

endmodule

// File: tb/tb_ok_fifo64x8_reader.sv
// Directed bench for ok_fifo64x8_reader with an in-order scoreboard on the output handshake.
module tb_ok_fifo64x8_reader;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       flush = 1'b0;
    logic       wr_en = 1'b0;
    logic [7:0] din = 8'h00;
    logic       full;
    logic [7:0] dout;
    logic       dout_valid;
    logic       dout_ready = 1'b0;
    logic [6:0] count;
    logic       almost_full;
    logic       almost_empty;
    logic       overflow;

    int n_chk  = 0;
    int n_fail = 0;
    logic [7:0] sb[$];

    ok_fifo64x8_reader #(.AFULL_THRESH(56), .AEMPTY_THRESH(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .flush        (flush),
        .wr_en        (wr_en),
        .din          (din),
        .full         (full),
        .dout         (dout),
        .dout_valid   (dout_valid),
        .dout_ready   (dout_ready),
        .count        (count),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .overflow     (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // One clock: score the handshake seen before the edge, then sample #1 after it.
    task automatic tick();
        bit wa, xf, hold;
        logic [7:0] prev;
        wa   = wr_en && !full && !flush && !reset;
        xf   = dout_valid && dout_ready && !flush && !reset;
        hold = dout_valid && !dout_ready && !flush && !reset;
        prev = dout;
        if (xf) begin
            if (sb.size() == 0) chk("xfer_unexpected", 1, 0);
            else chk("dout_order", dout, sb.pop_front());
        end
        if (wa) sb.push_back(din);
        if (flush) sb.delete();
        @(posedge clk);
        #1;
        if (hold) begin
            chk("stall_dout", dout, prev);
            chk("stall_vld", dout_valid, 1);
        end
    endtask

    task automatic fill(input int n, input int base);
        dout_ready = 1'b0;
        wr_en = 1'b1;
        for (int i = 0; i < n; i++) begin
            din = 8'(base + i);
            tick();
        end
        wr_en = 1'b0;
    endtask

    task automatic drain(input string tag);
        wr_en = 1'b0;
        dout_ready = 1'b1;
        for (int i = 0; i < 300 && count != 0; i++) tick();
        chk({tag, "_cnt"}, count, 0);
        chk({tag, "_sb"}, sb.size(), 0);
        chk({tag, "_vld"}, dout_valid, 0);
        dout_ready = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, failures so far %0d", n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values
        #12;
        chk("rst_full", full, 0);
        chk("rst_count", count, 0);
        chk("rst_aempty", almost_empty, 1);
        chk("rst_afull", almost_full, 0);
        chk("rst_vld", dout_valid, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_dout", dout, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Single word latency: visible two edges after the write edge
        wr_en = 1'b1;
        din = 8'hA5;
        tick();
        wr_en = 1'b0;
        chk("lat_e1_vld", dout_valid, 0);
        chk("lat_e1_cnt", count, 1);
        tick();
        chk("lat_e2_vld", dout_valid, 1);
        chk("lat_e2_dout", dout, 8'hA5);
        chk("lat_e2_cnt", count, 1);
        drain("lat_drain");

        // Fill 65 words, then one dropped write
        fill(65, 0);
        chk("full_cnt", count, 65);
        chk("full_flag", full, 1);
        chk("full_ovf0", overflow, 0);
        chk("full_head", dout, 0);
        wr_en = 1'b1;
        din = 8'd65;
        tick();
        wr_en = 1'b0;
        chk("ovf_set", overflow, 1);
        chk("ovf_cnt", count, 65);
        drain("full_drain");
        chk("ovf_sticky", overflow, 1);

        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_ovf", overflow, 0);

        // Almost-full / almost-empty thresholds
        fill(55, 100);
        chk("af55_cnt", count, 55);
        chk("af55", almost_full, 0);
        chk("ae55", almost_empty, 0);
        fill(1, 155);
        chk("af56_cnt", count, 56);
        chk("af56", almost_full, 1);
        dout_ready = 1'b1;
        for (int i = 0; i < 100 && count > 9; i++) tick();
        chk("ae9_cnt", count, 9);
        chk("ae9", almost_empty, 0);
        tick();
        chk("ae8_cnt", count, 8);
        chk("ae8", almost_empty, 1);

        // Random backpressure around half full
        fill(24, 200);
        chk("half_cnt", count, 32);
        for (int i = 0; i < 150; i++) begin
            dout_ready = 1'($urandom_range(0, 1));
            wr_en = 1'($urandom_range(0, 1));
            din = 8'($urandom);
            tick();
        end
        drain("rand_drain");

        // Sustained stream with pointer wrap
        wr_en = 1'b1;
        dout_ready = 1'b1;
        for (int i = 0; i < 200; i++) begin
            din = 8'(i);
            tick();
            if (i >= 1) chk("stream_vld", dout_valid, 1);
        end
        drain("stream_drain");

        // Flush together with a write at count=30
        fill(30, 40);
        chk("pre_flush_cnt", count, 30);
        flush = 1'b1;
        wr_en = 1'b1;
        din = 8'hEE;
        tick();
        flush = 1'b0;
        wr_en = 1'b0;
        chk("flush_cnt", count, 0);
        chk("flush_vld", dout_valid, 0);
        chk("flush_ovf2", overflow, 0);
        tick();
        tick();
        chk("flush_nostore_cnt", count, 0);
        chk("flush_nostore_vld", dout_valid, 0);

        // Overflow, then asynchronous reset mid-stream
        fill(66, 0);
        chk("pre_rst_ovf", overflow, 1);
        wr_en = 1'b1;
        dout_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            din = 8'(90 + i);
            tick();
        end
        #3;
        reset = 1'b1;
        wr_en = 1'b0;
        #1;
        chk("arst_cnt", count, 0);
        chk("arst_vld", dout_valid, 0);
        chk("arst_ovf", overflow, 0);
        chk("arst_full", full, 0);
        chk("arst_dout", dout, 0);
        chk("arst_ae", almost_empty, 1);
        @(posedge clk);
        #1;
        reset = 1'b0;
        sb.delete();
        dout_ready = 1'b0;
        wr_en = 1'b1;
        din = 8'h3C;
        tick();
        wr_en = 1'b0;
        tick();
        chk("post_rst_vld", dout_valid, 1);
        chk("post_rst_dout", dout, 8'h3C);
        drain("post_rst_drain");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
